pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed EXE/MEM pipeline register: one generic stage register for any inter-stage boundary (ID/EXE, EXE/MEM, MEM/WB).
- Adds valid/ready handshake, back-pressure (stall), synchronous flush with bubble insertion, and an optional one-entry skid buffer so upstream ready carries no combinational path from downstream.
- Sits between two pipeline stages; the upstream stage drives in_*, the downstream stage consumes out_*.

Parameters:
- DSIZE, 16: width of ALU-result and store-data fields.
- ASIZE, 5: width of register write address.
- CTRL_W, 3: width of control bundle; bit assignments come from the package.
- SKID, 1: 1 = two-entry skid mode (registered in_ready); 0 = single-register mode (in_ready combinational).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts in_* this cycle
- in_aluout  in  DSIZE  ALU result
- in_rdata2  in  DSIZE  store data
- in_waddr  in  ASIZE  destination register
- in_ctrl  in  CTRL_W  control bundle (wen, memtoreg, memwrite)
- out_valid  out  1  out_* hold a valid instruction
- out_ready  in  1  downstream consumes out_* this cycle
- out_aluout  out  DSIZE
- out_rdata2  out  DSIZE
- out_waddr  out  ASIZE
- out_ctrl  out  CTRL_W  gated to 0 whenever out_valid=0

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-high. While rst=1, in_ready=0. On the cycle after rst: out_valid=0, all out_* = 0, skid empty, in_ready=1.
- Transfer rules:
  - Accept occurs when in_valid & in_ready. Emit occurs when out_valid & out_ready.
  - Latency is 1 cycle: an accepted word appears on out_* the next cycle.
  - Throughput is 1 word/cycle when out_ready=1.
- SKID=1 state: main register (M) plus skid register (S), each with its own valid bit. in_ready = ~S_valid & ~rst, driven from a register only.
  - EMPTY (M, S invalid): accept -> M; state becomes ONE.
  - ONE (M valid): accept with emit -> M reloads; accept without emit -> S loads, state becomes FULL; emit without accept -> EMPTY.
  - FULL (M, S valid): in_ready=0. Emit -> S moves to M, state becomes ONE. No emit -> hold.
  - No word is ever dropped or duplicated; order is preserved.
- SKID=0: M only, no S. in_ready = (~out_valid | out_ready) & ~rst, which is a combinational path. Accept loads M; emit without accept clears out_valid.
- Stall: out_ready=0 with out_valid=1 holds out_* stable every cycle until emit.
- Flush:
  - Next cycle: M_valid=0, S_valid=0, out_ctrl=0.
  - A same-cycle accept is discarded; flush has priority over accept and emit.
  - Data fields may keep stale values, but ctrl must be 0.
- Bubble: any cycle with out_valid=0 presents out_ctrl=0, so no spurious wen or memwrite reaches MEM/WB.
- Reset mid-operation: identical to reset from idle; rst overrides flush and all handshakes.
- Width: fields pass bit-exact with no sign extension; all widths are set by parameters.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W and the bit indices CTRL_WEN=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2;
  - a payload width localparam PAYLOAD_W = 2*DSIZE+ASIZE+CTRL_W.
- The payload is concatenated into one vector internally.
- Natural sub-module: pipe_slot, a single valid+payload register with load/clear/hold. It is instantiated as M and, when SKID=1, as S.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_ctrl=3'b111 -> in_ready=0 during rst; after release out_valid=0, out_ctrl=0, out_aluout=0.
- Streaming: SKID=1, out_ready=1, send aluout 0x0001..0x0008 back-to-back -> each appears 1 cycle later in order; in_ready stays 1.
- Back-pressure: send 0x00A1, 0x00A2, 0x00A3, with out_ready=0 from the cycle 0x00A1 appears -> 0x00A1 held on out_*, 0x00A2 in skid, in_ready=0 and 0x00A3 is held upstream. Release out_ready -> 0x00A1, 0x00A2, 0x00A3 emerge in order with no loss.
- Flush with full skid: assert flush while FULL and in_valid=1 (waddr 5'd7) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; waddr 7 is never emitted.
- Bubble gating: in_valid=0 for 3 cycles between writes -> out_ctrl=0 in each gap cycle, and wen never pulses.
- SKID=0 mode: out_ready=0 with M valid -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 in the same cycle -> M reloads with the new word, and out_valid stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
package pipe_pkg;

  localparam int unsigned DSIZE_DEF = 16;
  localparam int unsigned ASIZE_DEF = 5;
  localparam int unsigned CTRL_W    = 3;

  localparam int unsigned CTRL_WEN      = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;

  function automatic int unsigned payload_w(input int unsigned dsize, input int unsigned asize,
                                            input int unsigned ctrl_w);
    return 2 * dsize + asize + ctrl_w;
  endfunction

  localparam int unsigned PAYLOAD_W = payload_w(DSIZE_DEF, ASIZE_DEF, CTRL_W);

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus payload register; clear beats load, reset beats both.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Clear drops only the valid bit; stale data is harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and optional skid entry.
module pipe_stage_reg #(
  parameter int unsigned DSIZE  = pipe_pkg::DSIZE_DEF,
  parameter int unsigned ASIZE  = pipe_pkg::ASIZE_DEF,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DSIZE-1:0]  in_aluout,
  input  logic [DSIZE-1:0]  in_rdata2,
  input  logic [ASIZE-1:0]  in_waddr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  out_aluout,
  output logic [DSIZE-1:0]  out_rdata2,
  output logic [ASIZE-1:0]  out_waddr,
  output logic [CTRL_W-1:0] out_ctrl
);

  import pipe_pkg::*;

  localparam int unsigned PW = payload_w(DSIZE, ASIZE, CTRL_W);

  logic [PW-1:0]     in_data;
  logic [PW-1:0]     m_din;
  logic [PW-1:0]     m_data;
  logic              m_valid;
  logic              m_load;
  logic              m_clear;
  logic              accept;
  logic              emit;
  logic [CTRL_W-1:0] m_ctrl;

  assign in_data = {in_aluout, in_rdata2, in_waddr, in_ctrl};
  assign accept  = in_valid & in_ready;
  assign emit    = m_valid & out_ready;

  pipe_slot #(
    .W (PW)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_din),
    .valid (m_valid),
    .q     (m_data)
  );

  if (SKID != 0) begin : g_skid
    logic          s_valid;
    logic [PW-1:0] s_data;
    logic          s_load;
    logic          s_clear;

    pipe_slot #(
      .W (PW)
    ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (s_load),
      .clear (s_clear),
      .d     (in_data),
      .valid (s_valid),
      .q     (s_data)
    );

    // in_ready depends only on the skid valid register, never on out_ready.
    assign in_ready = ~s_valid & ~rst;

    always_comb begin
      m_din   = in_data;
      m_load  = 1'b0;
      m_clear = flush;
      s_load  = 1'b0;
      s_clear = flush;
      if (s_valid) begin
        m_din   = s_data;
        m_load  = emit;
        s_clear = flush | emit;
      end else begin
        m_load  = accept & (emit | ~m_valid);
        m_clear = flush | (emit & ~accept);
        s_load  = accept & m_valid & ~emit;
      end
    end
  end else begin : g_single
    assign in_ready = (~m_valid | out_ready) & ~rst;

    always_comb begin
      m_din   = in_data;
      m_load  = accept;
      m_clear = flush | (emit & ~accept);
    end
  end

  assign out_valid = m_valid;
  assign {out_aluout, out_rdata2, out_waddr, m_ctrl} = m_data;
  // Bubbles must never carry a live wen/memwrite downstream.
  assign out_ctrl = m_valid ? m_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of pipe_stage_reg in skid (dut) and single-register (dut0) modes.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_aluout, in_rdata2, out_aluout, out_rdata2;
  logic [4:0]  in_waddr, out_waddr;
  logic [2:0]  in_ctrl, out_ctrl;

  logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [15:0] z_in_aluout, z_in_rdata2, z_out_aluout, z_out_rdata2;
  logic [4:0]  z_in_waddr, z_out_waddr;
  logic [2:0]  z_in_ctrl, z_out_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DSIZE  (16),
    .ASIZE  (5),
    .CTRL_W (3),
    .SKID   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluout  (in_aluout),
    .in_rdata2  (in_rdata2),
    .in_waddr   (in_waddr),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_aluout (out_aluout),
    .out_rdata2 (out_rdata2),
    .out_waddr  (out_waddr),
    .out_ctrl   (out_ctrl)
  );

  pipe_stage_reg #(
    .DSIZE  (16),
    .ASIZE  (5),
    .CTRL_W (3),
    .SKID   (0)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .flush      (z_flush),
    .in_valid   (z_in_valid),
    .in_ready   (z_in_ready),
    .in_aluout  (z_in_aluout),
    .in_rdata2  (z_in_rdata2),
    .in_waddr   (z_in_waddr),
    .in_ctrl    (z_in_ctrl),
    .out_valid  (z_out_valid),
    .out_ready  (z_out_ready),
    .out_aluout (z_out_aluout),
    .out_rdata2 (z_out_rdata2),
    .out_waddr  (z_out_waddr),
    .out_ctrl   (z_out_ctrl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [4:0] wa,
                       input logic [2:0] ctl);
    in_valid  = v;
    in_aluout = alu;
    in_rdata2 = ~alu;
    in_waddr  = wa;
    in_ctrl   = ctl;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h0055, 5'd9, 3'b111);
    z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0;
    z_in_aluout = '0; z_in_rdata2 = '0; z_in_waddr = '0; z_in_ctrl = '0;

    // Reset with a valid upstream word held
    #1;
    check("rst_in_ready_a", in_ready, 0);
    tick();
    check("rst_in_ready_b", in_ready, 0);
    tick();
    check("rst_in_ready_c", in_ready, 0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_aluout", out_aluout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_z_in_ready", z_in_ready, 1);

    // Streaming 1..8 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 5'(i), 3'b001);
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_aluout", out_aluout, i);
      check("stream_rdata2", out_rdata2, {16'h0, ~16'(i)});
      check("stream_waddr", out_waddr, i);
    end
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_ctrl", out_ctrl, 0);

    // Back-pressure fills the skid entry
    drive(1'b1, 16'h00A1, 5'd1, 3'b001);
    tick();
    check("bp_a1_out", out_aluout, 16'h00A1);
    out_ready = 1'b0;
    drive(1'b1, 16'h00A2, 5'd2, 3'b001);
    #1;
    check("bp_ready_before_full", in_ready, 1);
    tick();
    drive(1'b1, 16'h00A3, 5'd3, 3'b001);
    #1;
    check("bp_full_in_ready", in_ready, 0);
    check("bp_hold_a1", out_aluout, 16'h00A1);
    tick();
    check("bp_hold_a1_again", out_aluout, 16'h00A1);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_out_a2", out_aluout, 16'h00A2);
    check("bp_ready_after", in_ready, 1);
    tick();
    check("bp_out_a3", out_aluout, 16'h00A3);
    check("bp_out_a3_valid", out_valid, 1);
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    tick();
    check("bp_drained", out_valid, 0);

    // Flush while FULL, with waddr 7 offered upstream
    out_ready = 1'b0;
    drive(1'b1, 16'h00B1, 5'd1, 3'b011);
    tick();
    drive(1'b1, 16'h00B2, 5'd2, 3'b011);
    tick();
    check("fl_full", in_ready, 0);
    drive(1'b1, 16'h00B7, 5'd7, 3'b111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    #1;
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    check("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_emit", out_valid, 0);
    end

    // Flush beats a same-cycle accept in ONE state
    drive(1'b1, 16'h00C1, 5'd4, 3'b001);
    tick();
    check("fl1_loaded", out_aluout, 16'h00C1);
    drive(1'b1, 16'h00C2, 5'd5, 3'b001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    check("fl1_valid", out_valid, 0);
    check("fl1_ctrl", out_ctrl, 0);

    // Bubble gating between writes
    drive(1'b1, 16'h00D1, 5'd3, 3'b001);
    tick();
    check("bub_w1_ctrl", out_ctrl, 3'b001);
    drive(1'b0, 16'h00EE, 5'd6, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_gap_ctrl", out_ctrl, 0);
      check("bub_gap_valid", out_valid, 0);
    end
    drive(1'b1, 16'h00D2, 5'd3, 3'b101);
    tick();
    check("bub_w2_ctrl", out_ctrl, 3'b101);
    check("bub_w2_aluout", out_aluout, 16'h00D2);
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    tick();

    // Reset mid-operation
    out_ready = 1'b0;
    drive(1'b1, 16'h00E1, 5'd1, 3'b001);
    tick();
    tick();
    rst = 1'b1;
    flush = 1'b1;
    tick();
    check("mrst_in_ready", in_ready, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_ctrl", out_ctrl, 0);
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 16'h0, 5'd0, 3'b000);
    #1;
    check("mrst_ready_after", in_ready, 1);
    check("mrst_aluout", out_aluout, 0);

    // Single-register mode: combinational in_ready
    z_out_ready = 1'b0;
    z_in_valid  = 1'b1;
    z_in_aluout = 16'h0011;
    z_in_waddr  = 5'd2;
    z_in_ctrl   = 3'b001;
    #1;
    check("z_empty_ready", z_in_ready, 1);
    tick();
    z_in_aluout = 16'h0022;
    z_in_ctrl   = 3'b100;
    #1;
    check("z_stall_ready", z_in_ready, 0);
    check("z_m_out", z_out_aluout, 16'h0011);
    tick();
    check("z_hold", z_out_aluout, 16'h0011);
    z_out_ready = 1'b1;
    #1;
    check("z_same_cycle_ready", z_in_ready, 1);
    tick();
    check("z_reload", z_out_aluout, 16'h0022);
    check("z_reload_valid", z_out_valid, 1);
    check("z_reload_ctrl", z_out_ctrl, 3'b100);
    z_in_valid = 1'b0;
    tick();
    check("z_drain_valid", z_out_valid, 0);
    check("z_drain_ctrl", z_out_ctrl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
